// File: rtl/rtc_alarm_clock.sv
// Time-of-day clock (HH:MM:SS) with built-in prescaler, run/pause, minute/hour adjust,
// 12/24-hour display, day-rollover pulse and a single alarm with timeout and acknowledge.
module rtc_alarm_clock #(
    parameter int unsigned CLK_DIV   = 50000000,
    parameter int unsigned RING_SECS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       load,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [4:0] hour_in,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       mode_12h,
    input  logic       alarm_set,
    input  logic [5:0] alarm_min_in,
    input  logic [4:0] alarm_hour_in,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [4:0] hour_out,
    output logic [4:0] disp_hour,
    output logic       pm,
    output logic       sec_pulse,
    output logic       day_pulse,
    output logic       alarm_ring
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RW = $clog2(RING_SECS + 1);
    localparam logic [PW-1:0] DIV_MAX   = PW'(CLK_DIV - 1);
    localparam logic [RW-1:0] RING_INIT = RW'(RING_SECS);

    logic [PW-1:0] pre_cnt;
    logic [RW-1:0] ring_cnt;
    logic [5:0]    alarm_min;
    logic [4:0]    alarm_hour;

    logic       tick;
    logic       adjust;
    logic       tick_time;
    logic       match;
    logic [6:0] sec_p1;
    logic [6:0] min_p1;
    logic [5:0] hour_p1;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hour_wrap;
    logic [5:0] sec_step;
    logic [5:0] min_step;
    logic [4:0] hour_step;
    logic [5:0] tick_min;
    logic [4:0] tick_hour;
    logic [5:0] sec_ld;
    logic [5:0] min_ld;
    logic [4:0] hour_ld;
    logic [5:0] alarm_min_ld;
    logic [4:0] alarm_hour_ld;

    // One-wider increments so the wrap compare never overflows the field
    assign sec_p1    = {1'b0, sec_out} + 7'd1;
    assign min_p1    = {1'b0, min_out} + 7'd1;
    assign hour_p1   = {1'b0, hour_out} + 6'd1;
    assign sec_wrap  = (sec_p1 >= 7'd60);
    assign min_wrap  = (min_p1 >= 7'd60);
    assign hour_wrap = (hour_p1 >= 6'd24);
    assign sec_step  = sec_wrap  ? 6'd0 : sec_p1[5:0];
    assign min_step  = min_wrap  ? 6'd0 : min_p1[5:0];
    assign hour_step = hour_wrap ? 5'd0 : hour_p1[4:0];

    assign sec_ld        = (sec_in < 6'd60)        ? sec_in        : 6'd0;
    assign min_ld        = (min_in < 6'd60)        ? min_in        : 6'd0;
    assign hour_ld       = (hour_in < 5'd24)       ? hour_in       : 5'd0;
    assign alarm_min_ld  = (alarm_min_in < 6'd60)  ? alarm_min_in  : 6'd0;
    assign alarm_hour_ld = (alarm_hour_in < 5'd24) ? alarm_hour_in : 5'd0;

    assign tick      = run && (pre_cnt == DIV_MAX);
    assign adjust    = inc_min | inc_hour;
    assign tick_time = tick && !load && !adjust;
    assign tick_min  = sec_wrap ? min_step : min_out;
    assign tick_hour = (sec_wrap && min_wrap) ? hour_step : hour_out;

    // Alarm only fires when a plain tick carries the clock onto HH:MM:00
    assign match = tick_time && alarm_en && sec_wrap &&
                   (tick_min == alarm_min) && (tick_hour == alarm_hour);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt   <= '0;
            sec_out   <= 6'd0;
            min_out   <= 6'd0;
            hour_out  <= 5'd0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            if (load) begin
                pre_cnt  <= '0;
                sec_out  <= sec_ld;
                min_out  <= min_ld;
                hour_out <= hour_ld;
            end else begin
                if (run) begin
                    pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
                end
                if (adjust) begin
                    // Coincident tick still moves seconds but its carry is dropped
                    if (inc_min) begin
                        min_out <= min_step;
                    end
                    if (inc_hour) begin
                        hour_out <= hour_step;
                    end
                    if (tick) begin
                        sec_out   <= sec_step;
                        sec_pulse <= 1'b1;
                    end
                end else if (tick) begin
                    sec_out   <= sec_step;
                    min_out   <= tick_min;
                    hour_out  <= tick_hour;
                    sec_pulse <= 1'b1;
                    day_pulse <= sec_wrap && min_wrap && hour_wrap;
                end
            end
        end
    end

    // Alarm registers and ring timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_min  <= 6'd0;
            alarm_hour <= 5'd0;
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
        end else begin
            if (alarm_set) begin
                alarm_min  <= alarm_min_ld;
                alarm_hour <= alarm_hour_ld;
            end
            if (match) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= RING_INIT;
            end else if (alarm_ring && (alarm_ack || !alarm_en)) begin
                alarm_ring <= 1'b0;
                ring_cnt   <= '0;
            end else if (alarm_ring && tick && !load) begin
                if (ring_cnt <= RW'(1)) begin
                    alarm_ring <= 1'b0;
                    ring_cnt   <= '0;
                end else begin
                    ring_cnt <= ring_cnt - RW'(1);
                end
            end
        end
    end

    // Display hour: 0 shows as 12, 13..23 fold down by 12 in 12-hour mode
    always_comb begin
        disp_hour = hour_out;
        if (mode_12h) begin
            if (hour_out == 5'd0) begin
                disp_hour = 5'd12;
            end else if (hour_out > 5'd12) begin
                disp_hour = hour_out - 5'd12;
            end
        end
    end

    assign pm = (hour_out >= 5'd12);

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Bench for rtc_alarm_clock: seconds-of-day reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rtc_alarm_clock;

    localparam int CLK_DIV   = 4;
    localparam int RING_SECS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [5:0] sec_in = 6'd0;
    logic [5:0] min_in = 6'd0;
    logic [4:0] hour_in = 5'd0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       mode_12h = 1'b0;
    logic       alarm_set = 1'b0;
    logic [5:0] alarm_min_in = 6'd0;
    logic [4:0] alarm_hour_in = 5'd0;
    logic       alarm_en = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [5:0] sec_out;
    logic [5:0] min_out;
    logic [4:0] hour_out;
    logic [4:0] disp_hour;
    logic       pm;
    logic       sec_pulse;
    logic       day_pulse;
    logic       alarm_ring;

    int total = 0;
    int bad = 0;

    rtc_alarm_clock #(.CLK_DIV(CLK_DIV), .RING_SECS(RING_SECS)) dut (
        .clk(clk), .reset(reset), .run(run), .load(load),
        .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .inc_min(inc_min), .inc_hour(inc_hour), .mode_12h(mode_12h),
        .alarm_set(alarm_set), .alarm_min_in(alarm_min_in), .alarm_hour_in(alarm_hour_in),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .sec_out(sec_out), .min_out(min_out), .hour_out(hour_out),
        .disp_hour(disp_hour), .pm(pm), .sec_pulse(sec_pulse),
        .day_pulse(day_pulse), .alarm_ring(alarm_ring)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time kept as seconds since midnight
    int m_tod, m_pre, m_rem, m_ah, m_am;
    bit m_ring, m_sp, m_dp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tod = 0; m_pre = 0; m_rem = 0; m_ah = 0; m_am = 0;
            m_ring = 0; m_sp = 0; m_dp = 0;
        end else begin
            bit t, hit;
            int h, m, s;
            t = run && (m_pre == CLK_DIV - 1);
            hit = 0;
            m_sp = 0;
            m_dp = 0;
            if (load) begin
                h = (hour_in < 24) ? int'(hour_in) : 0;
                m = (min_in < 60) ? int'(min_in) : 0;
                s = (sec_in < 60) ? int'(sec_in) : 0;
                m_tod = h * 3600 + m * 60 + s;
                m_pre = 0;
            end else begin
                if (run) m_pre = t ? 0 : m_pre + 1;
                if (inc_min || inc_hour) begin
                    h = m_tod / 3600;
                    m = (m_tod / 60) % 60;
                    s = m_tod % 60;
                    if (inc_min) m = (m + 1) % 60;
                    if (inc_hour) h = (h + 1) % 24;
                    if (t) s = (s + 1) % 60;
                    m_sp = t;
                    m_tod = h * 3600 + m * 60 + s;
                end else if (t) begin
                    m_tod = (m_tod + 1) % 86400;
                    m_sp = 1;
                    m_dp = (m_tod == 0);
                    hit = alarm_en && (m_tod == m_ah * 3600 + m_am * 60);
                end
            end
            if (hit) begin
                m_ring = 1; m_rem = RING_SECS;
            end else if (m_ring && (alarm_ack || !alarm_en)) begin
                m_ring = 0;
            end else if (m_ring && t && !load) begin
                m_rem--;
                if (m_rem == 0) m_ring = 0;
            end
            if (alarm_set) begin
                m_am = (alarm_min_in < 60) ? int'(alarm_min_in) : 0;
                m_ah = (alarm_hour_in < 24) ? int'(alarm_hour_in) : 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int h;
        h = m_tod / 3600;
        check("sec", 32'(sec_out), 32'(m_tod % 60));
        check("min", 32'(min_out), 32'((m_tod / 60) % 60));
        check("hour", 32'(hour_out), 32'(h));
        check("disp_hour", 32'(disp_hour), 32'(mode_12h ? ((h + 11) % 12) + 1 : h));
        check("pm", 32'(pm), 32'(h >= 12));
        check("sec_pulse", 32'(sec_pulse), 32'(m_sp));
        check("day_pulse", 32'(day_pulse), 32'(m_dp));
        check("alarm_ring", 32'(alarm_ring), 32'(m_ring));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load_time(input int h, input int m, input int s);
        load = 1'b1; hour_in = 5'(h); min_in = 6'(m); sec_in = 6'(s);
        cyc(1);
        load = 1'b0;
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, ".h"}, 32'(hour_out), 32'(h));
        check({name, ".m"}, 32'(min_out), 32'(m));
        check({name, ".s"}, 32'(sec_out), 32'(s));
    endtask

    initial begin
        int pulses;
        #1 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check_time("reset", 0, 0, 0);
        check("reset.ring", 32'(alarm_ring), 32'd0);

        // Free running: 20 cycles at divide-by-4 gives 5 seconds
        run = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (sec_pulse) pulses++;
        end
        check("run.pulses", 32'(pulses), 32'd5);
        check_time("run", 0, 0, 5);

        // Midnight rollover
        load_time(23, 59, 58);
        cyc(4);
        check_time("pre_midnight", 23, 59, 59);
        cyc(4);
        check_time("midnight", 0, 0, 0);
        check("midnight.day_pulse", 32'(day_pulse), 32'd1);
        check("midnight.sec_pulse", 32'(sec_pulse), 32'd1);
        cyc(1);
        check("after_midnight.day_pulse", 32'(day_pulse), 32'd0);

        // Out-of-range load and 12-hour display
        load_time(24, 30, 61);
        check_time("sanitize", 0, 30, 0);
        mode_12h = 1'b1;
        load_time(0, 0, 0);
        check("h0.disp", 32'(disp_hour), 32'd12);
        check("h0.pm", 32'(pm), 32'd0);
        load_time(12, 0, 0);
        check("h12.disp", 32'(disp_hour), 32'd12);
        check("h12.pm", 32'(pm), 32'd1);
        load_time(13, 0, 0);
        check("h13.disp", 32'(disp_hour), 32'd1);
        check("h13.pm", 32'(pm), 32'd1);
        mode_12h = 1'b0;

        // inc_min coinciding with a tick: no carry into the hour
        load_time(10, 59, 59);
        cyc(3);
        inc_min = 1'b1;
        cyc(1);
        inc_min = 1'b0;
        check_time("inc_tick", 10, 0, 0);
        check("inc_tick.sec_pulse", 32'(sec_pulse), 32'd1);
        check("inc_tick.day_pulse", 32'(day_pulse), 32'd0);
        load_time(23, 0, 0);
        inc_hour = 1'b1;
        cyc(1);
        inc_hour = 1'b0;
        check("inc_hour.wrap", 32'(hour_out), 32'd0);
        inc_min = 1'b1; inc_hour = 1'b1;
        cyc(1);
        inc_min = 1'b0; inc_hour = 1'b0;
        check_time("inc_both", 1, 1, 0);

        // Alarm: rings for RING_SECS seconds
        alarm_set = 1'b1; alarm_hour_in = 5'd7; alarm_min_in = 6'd0; alarm_en = 1'b1;
        cyc(1);
        alarm_set = 1'b0;
        load_time(6, 59, 58);
        cyc(8);
        check_time("ring_rise", 7, 0, 0);
        check("ring_rise.ring", 32'(alarm_ring), 32'd1);
        cyc(11);
        check("ring_hold.ring", 32'(alarm_ring), 32'd1);
        cyc(1);
        check_time("ring_fall", 7, 0, 3);
        check("ring_fall.ring", 32'(alarm_ring), 32'd0);

        // Alarm again: pause holds the ring, ack stops it
        load_time(6, 59, 58);
        cyc(8);
        check("ring2_rise.ring", 32'(alarm_ring), 32'd1);
        cyc(4);
        check_time("ring2_at1", 7, 0, 1);
        run = 1'b0;
        cyc(10);
        check("paused.ring", 32'(alarm_ring), 32'd1);
        check("paused.sec", 32'(sec_out), 32'd1);
        run = 1'b1;
        alarm_ack = 1'b1;
        cyc(1);
        alarm_ack = 1'b0;
        check("ack.ring", 32'(alarm_ring), 32'd0);

        // Async reset mid-prescale and mid-ring
        load_time(6, 59, 58);
        cyc(8);
        check("ring3_rise.ring", 32'(alarm_ring), 32'd1);
        cyc(2);
        #1 reset = 1'b1;
        #1;
        check_time("async_reset", 0, 0, 0);
        check("async_reset.ring", 32'(alarm_ring), 32'd0);
        check("async_reset.sec_pulse", 32'(sec_pulse), 32'd0);
        cyc(1);
        reset = 1'b0;

        // Loading the alarm time directly never rings
        alarm_set = 1'b1; alarm_hour_in = 5'd7; alarm_min_in = 6'd0;
        load_time(7, 0, 0);
        alarm_set = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("no_ring_on_load", 32'(alarm_ring), 32'd0);
        end

        cyc(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtc_alarm_clock.md
Name: rtc_alarm_clock

Overview:
Parametrised time-of-day counter: HH:MM:SS with an internal prescaler, so it runs directly from the system clock with no external 1 Hz tick. Adds run/pause, minute and hour adjust inputs, 12/24-hour display output, a day-rollover pulse, and one alarm with timeout and acknowledge. It sits between the board clock and the display/keypad logic and replaces the bare 1 Hz HH:MM:SS counter.

Parameters:
CLK_DIV, 50000000, clk cycles per second (>=1); prescaler width is $clog2(CLK_DIV), minimum 1.
RING_SECS, 60, seconds alarm_ring stays asserted without ack (>=1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clock clk
run  in  1  1 = time advances; 0 = prescaler and time hold
load  in  1  synchronous load of sec_in/min_in/hour_in
sec_in  in  6  load value, seconds
min_in  in  6  load value, minutes
hour_in  in  5  load value, hours (24 h)
inc_min  in  1  single-cycle strobe: minute +1, wraps 59->0, no hour carry
inc_hour  in  1  single-cycle strobe: hour +1, wraps 23->0
mode_12h  in  1  selects disp_hour format
alarm_set  in  1  latch alarm_min_in/alarm_hour_in
alarm_min_in  in  6  alarm minute
alarm_hour_in  in  5  alarm hour (24 h)
alarm_en  in  1  alarm armed
alarm_ack  in  1  stops ringing
sec_out  out  6  seconds 0..59
min_out  out  6  minutes 0..59
hour_out  out  5  hours 0..23
disp_hour  out  5  hour for display (12 h or 24 h)
pm  out  1  hour_out >= 12
sec_pulse  out  1  1-cycle pulse on each tick-driven seconds update
day_pulse  out  1  1-cycle pulse on 23:59:59 -> 00:00:00
alarm_ring  out  1  alarm active

Behaviour:
- Reset (async): sec/min/hour=0, prescaler=0, alarm regs=0, alarm_ring=0, sec_pulse=0, day_pulse=0, ring counter=0.
- Prescaler: when run=1, counts 0..CLK_DIV-1. A tick occurs in the cycle where count==CLK_DIV-1; count then returns to 0. CLK_DIV=1 gives a tick every cycle. run=0 freezes the count.
- Priority per cycle: reset > load > inc_min/inc_hour > tick.
- load: each field is written; an out-of-range value (sec/min>=60, hour>=24) becomes 0. The prescaler clears to 0, and the tick in that cycle is discarded. No pulses.
- Adjust cycle (inc_min or inc_hour, both allowed together): the selected fields step with wrap. If a tick coincides, sec still advances (59->0), but its minute/hour carry and day_pulse are discarded. sec_pulse still fires.
- Tick (no load/inc): sec+1. On 59 sec wraps to 0 and carries to min; on 59 min wraps and carries to hour; on 23 hour wraps. sec_pulse=1 for that cycle. day_pulse=1 when 23:59:59 -> 00:00:00. Outputs update at the same edge as the pulses.
- Arithmetic is done at full width +1; no field ever holds an out-of-range value.
- disp_hour: combinational from hour_out. mode_12h=0 gives hour_out. mode_12h=1 gives 12 for hour 0, hour-12 for hours 13..23, else hour_out. pm is valid in both modes.
- alarm_set: latches alarm_min/alarm_hour; out-of-range values become 0. It does not affect ringing.
- Alarm match: only on a tick-driven update whose new time is alarm_hour:alarm_min:00 with alarm_en=1. alarm_ring rises at the same edge, and the ring counter loads RING_SECS. load/inc landing on the alarm time never triggers.
- Ringing: each subsequent tick decrements the ring counter; alarm_ring clears at the tick where the counter reaches 0. It also clears on the edge after alarm_ack=1 or alarm_en=0.
- If alarm_ack and a match occur in the same cycle, the match wins (ring restarts).
- Reset mid-ring clears alarm_ring immediately (async).
- run=0 while ringing: the ring counter holds; ack still clears.

Test Plan:
1. CLK_DIV=4: reset, run=1 for 20 cycles -> sec_pulse every 4th cycle, sec_out=5, min/hour=0.
2. load 23:59:58, 8 cycles -> 23:59:59, then 00:00:00 with day_pulse=1 for one cycle coincident with sec_pulse.
3. load sec_in=61, min_in=30, hour_in=24 -> 00:30:00. Set mode_12h=1 with hour 0/12/13 loaded -> disp_hour 12/12/1, pm 0/1/1.
4. At 10:59:59 pulse inc_min on the tick cycle -> 10:00:00, no hour carry, sec_pulse=1, day_pulse=0. Then inc_hour at 23 -> 0.
5. RING_SECS=3, alarm 07:00, alarm_en=1, load 06:59:58 -> ring rises at 07:00:00 and falls at 07:00:03. Repeat with alarm_ack at 07:00:01 -> falls the next cycle.
6. Assert reset mid-prescale and mid-ring -> all outputs 0 immediately. Load 07:00:00 directly with the alarm armed -> no ring.
